// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths and register-file helpers.
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // $0 is hardwired to zero, so writes to it must never reach regm.
  function automatic logic is_real_reg(input logic [REG_ADDR_W-1:0] r);
    return (r != REG_ZERO);
  endfunction
endpackage

// File: rtl/wb_starve_counter.sv
// Saturating counter tracking how long the mul/div writeback has been refused.
module wb_starve_counter #(
  parameter int MAX = 4,
  parameter int W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clear,
  output logic o_at_max
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  // Clear wins over increment; increment stops at MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clear) begin
      r_cnt <= {W{1'b0}};
    end else if (i_inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_at_max = (r_cnt == MAX_V);
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regm write port between pipeline (A) and mul/div (B)
// writeback, A first, with a starvation limit that forces a B grant.
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  write,
  output logic [REG_ADDR_W-1:0] wrreg,
  output logic [DATA_W-1:0]     wrdata,
  output logic                  b_starved
);
  logic w_at_max;
  logic w_force_b;
  logic w_b_grant;
  logic w_a_grant;

  wb_starve_counter #(
    .MAX (STARVE_MAX),
    .W   (CNT_W)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .i_inc    (b_valid & ~w_b_grant),
    .i_clear  (~b_valid | w_b_grant),
    .o_at_max (w_at_max)
  );

  // Grants are masked by reset so nothing is accepted while it is held.
  assign w_force_b = b_valid & w_at_max;
  assign w_b_grant = ~reset & b_valid & (~a_valid | w_force_b);
  assign w_a_grant = ~reset & a_valid & ~w_b_grant;

  assign a_ready   = w_a_grant;
  assign b_ready   = w_b_grant;
  assign b_starved = w_at_max;

  // Registered write port; address and data hold when nothing is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write  <= 1'b0;
      wrreg  <= REG_ZERO;
      wrdata <= {DATA_W{1'b0}};
    end else if (w_a_grant) begin
      write  <= is_real_reg(a_reg);
      wrreg  <= a_reg;
      wrdata <= a_data;
    end else if (w_b_grant) begin
      write  <= is_real_reg(b_reg);
      wrreg  <= b_reg;
      wrdata <= b_data;
    end else begin
      write  <= 1'b0;
      wrreg  <= wrreg;
      wrdata <= wrdata;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed vector table, reset sequence, random vs. model.
module tb_regfile_wb_arbiter;
  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        write;
  logic [4:0]  wrreg;
  logic [31:0] wrdata;
  logic        b_starved;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter #(.STARVE_MAX(SM), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .write(write), .wrreg(wrreg), .wrdata(wrdata), .b_starved(b_starved)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  br;
    logic [31:0] bd;
    logic        e_ar;
    logic        e_br;
    logic        e_bs;
    logic        e_wr;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic bv, input logic [4:0] br, input logic [31:0] bd,
                              input logic e_ar, input logic e_br, input logic e_bs,
                              input logic e_wr, input logic [4:0] e_reg, input logic [31:0] e_data);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
    v.e_ar = e_ar; v.e_br = e_br; v.e_bs = e_bs;
    v.e_wr = e_wr; v.e_reg = e_reg; v.e_data = e_data;
    return v;
  endfunction

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Reference model state
  int          m_cnt;
  logic        m_wr;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Directed table, starting from reset state
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(1, 5'd3, 32'hAAAA, 1, 5'd7, 32'hBBBB, 1, 0, 0, 1, 5'd3, 32'hAAAA));
    vt.push_back(mk(1, 5'd3, 32'hAAAA, 1, 5'd7, 32'hBBBB, 0, 1, 1, 1, 5'd7, 32'hBBBB));
    vt.push_back(mk(1, 5'd3, 32'hAAAA, 1, 5'd7, 32'hBBBB, 1, 0, 0, 1, 5'd3, 32'hAAAA));
    vt.push_back(mk(1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'hFFFF_FFFF));
    vt.push_back(mk(1, 5'd9, 32'h99, 0, 5'd0, 32'd0, 1, 0, 0, 1, 5'd9, 32'h99));
    for (int k = 1; k <= 4; k++)
      vt.push_back(mk(1, 5'(k), 32'(k * 32'h11), 0, 5'd0, 32'd0, 1, 0, 0, 1, 5'(k), 32'(k * 32'h11)));
    vt.push_back(mk(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0, 0, 5'd4, 32'h44));
    vt.push_back(mk(0, 5'd0, 32'd0, 1, 5'd12, 32'hC0C0, 0, 1, 0, 1, 5'd12, 32'hC0C0));
    vt.push_back(mk(1, 5'd0, 32'd0, 1, 5'd0, 32'h1, 1, 0, 0, 0, 5'd0, 32'd0));
    vt.push_back(mk(1, 5'd5, 32'h55, 1, 5'd7, 32'hBBBB, 1, 0, 0, 1, 5'd5, 32'h55));
    vt.push_back(mk(1, 5'd6, 32'h66, 0, 5'd7, 32'hBBBB, 1, 0, 0, 1, 5'd6, 32'h66));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(1, 5'd3, 32'hAAAA, 1, 5'd7, 32'hBBBB, 1, 0, 0, 1, 5'd3, 32'hAAAA));
    vt.push_back(mk(1, 5'd3, 32'hAAAA, 1, 5'd7, 32'hBBBB, 0, 1, 1, 1, 5'd7, 32'hBBBB));

    @(posedge clk); #1;
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_wrreg", {27'd0, wrreg}, 32'd0);
    check("rst_wrdata", wrdata, 32'd0);
    check("rst_starved", {31'd0, b_starved}, 32'd0);
    reset = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].av, vt[i].ar, vt[i].ad, vt[i].bv, vt[i].br, vt[i].bd);
      #1;
      check($sformatf("vec%0d_a_ready", i), {31'd0, a_ready}, {31'd0, vt[i].e_ar});
      check($sformatf("vec%0d_b_ready", i), {31'd0, b_ready}, {31'd0, vt[i].e_br});
      check($sformatf("vec%0d_b_starved", i), {31'd0, b_starved}, {31'd0, vt[i].e_bs});
      @(posedge clk); #1;
      check($sformatf("vec%0d_write", i), {31'd0, write}, {31'd0, vt[i].e_wr});
      check($sformatf("vec%0d_wrreg", i), {27'd0, wrreg}, {27'd0, vt[i].e_reg});
      check($sformatf("vec%0d_wrdata", i), wrdata, vt[i].e_data);
    end

    // Asynchronous reset mid-cycle with a request pending and a write registered
    drive(1, 5'd8, 32'hDEAD, 1, 5'd7, 32'hBBBB);
    @(posedge clk); #1;
    check("pre_rst_write", {31'd0, write}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_write", {31'd0, write}, 32'd0);
    check("async_rst_wrreg", {27'd0, wrreg}, 32'd0);
    check("async_rst_wrdata", wrdata, 32'd0);
    check("async_rst_a_ready", {31'd0, a_ready}, 32'd0);
    check("async_rst_b_ready", {31'd0, b_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1, 5'd5, 32'h1234, 0, 5'd0, 32'd0);
    @(posedge clk); #1;
    check("post_rst_write", {31'd0, write}, 32'd1);
    check("post_rst_wrreg", {27'd0, wrreg}, 32'd5);
    check("post_rst_wrdata", wrdata, 32'h1234);

    // Random traffic against a rule-level model
    do_reset();
    m_cnt = 0; m_wr = 1'b0; m_reg = 5'd0; m_data = 32'd0;
    for (int c = 0; c < 400; c++) begin
      logic av, bv, ea, eb;
      logic [4:0] ar, br;
      logic [31:0] ad, bd;
      av = ($urandom_range(0, 99) < 75);
      bv = ($urandom_range(0, 99) < 60);
      ar = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      br = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ad = $urandom;
      bd = $urandom;
      drive(av, ar, ad, bv, br, bd);
      eb = bv && (!av || (m_cnt == SM));
      ea = av && !eb;
      #1;
      check("rnd_a_ready", {31'd0, a_ready}, {31'd0, ea});
      check("rnd_b_ready", {31'd0, b_ready}, {31'd0, eb});
      check("rnd_b_starved", {31'd0, b_starved}, (m_cnt == SM) ? 32'd1 : 32'd0);
      if (ea) begin
        m_wr = (ar != 5'd0); m_reg = ar; m_data = ad;
      end else if (eb) begin
        m_wr = (br != 5'd0); m_reg = br; m_data = bd;
      end else begin
        m_wr = 1'b0;
      end
      if (bv && !eb) m_cnt = (m_cnt < SM) ? m_cnt + 1 : SM;
      else           m_cnt = 0;
      @(posedge clk); #1;
      check("rnd_write", {31'd0, write}, {31'd0, m_wr});
      check("rnd_wrreg", {27'd0, wrreg}, {27'd0, m_reg});
      check("rnd_wrdata", wrdata, m_data);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
